// File: rtl/writeback_unit.sv
// -----------------------------------------------------------------------------
// writeback_unit
// Register-file write-back stage of the pipelined RISC core. It takes one
// instruction per cycle from the MEM/WB boundary, selects its result
// (ALU / MEM / PORT / IMM) and presents a registered register-file write.
// A double-word memory load writes two consecutive registers over two cycles
// and holds off the MEM stage (in_ready low) for the second cycle. A
// retired-instruction counter is kept for debug/performance monitoring.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   MEM-stage handshake; in_ready depends on state only
//   flush               synchronous squash of everything pending
//   wb_en, src_sel, dbl, dst           instruction control fields
//   alu_data, mem_data, port_data,
//   imm_data, mem_data_hi              source operands
//   rf_we, rf_waddr, rf_wdata          registered register-file write port
//   retire_cnt                         completed-instruction count (wraps)
// -----------------------------------------------------------------------------
module writeback_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [1:0]        src_sel,
  input  logic              dbl,
  input  logic [ADDR_W-1:0] dst,
  input  logic [DATA_W-1:0] alu_data,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] port_data,
  input  logic [DATA_W-1:0] imm_data,
  input  logic [DATA_W-1:0] mem_data_hi,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [CNT_W-1:0]  retire_cnt
);

  typedef enum logic {NORM = 1'b0, HI = 1'b1} wbState_t;

  localparam logic [1:0] SRC_ALU  = 2'd0;
  localparam logic [1:0] SRC_MEM  = 2'd1;
  localparam logic [1:0] SRC_PORT = 2'd2;

  wbState_t          state;
  wbState_t          nextState;
  logic              accept;
  logic              effDbl;
  logic [DATA_W-1:0] selData;
  logic [DATA_W-1:0] hiData;
  logic [ADDR_W-1:0] hiAddr;

  function automatic logic [DATA_W-1:0] selectSrc(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] aluVal,
    input logic [DATA_W-1:0] memVal,
    input logic [DATA_W-1:0] portVal,
    input logic [DATA_W-1:0] immVal
  );
    case (sel)
      SRC_ALU:  return aluVal;
      SRC_MEM:  return memVal;
      SRC_PORT: return portVal;
      default:  return immVal;
    endcase
  endfunction

  // in_ready is high only in NORM, so accept can never happen in HI.
  assign accept  = in_valid & in_ready & ~flush;
  // dbl is ignored unless this is a register-writing memory load.
  assign effDbl  = dbl & wb_en & (src_sel == SRC_MEM);
  assign selData = selectSrc(src_sel, alu_data, mem_data, port_data, imm_data);

  // ---- FSM: state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= NORM;
    else     state <= nextState;
  end

  // ---- FSM: next-state logic ----
  always_comb begin
    nextState = state;
    if (flush) begin
      nextState = NORM;
    end else begin
      case (state)
        NORM:    if (accept && effDbl) nextState = HI;
        HI:      nextState = NORM;
        default: nextState = NORM;
      endcase
    end
  end

  // ---- FSM: outputs ----
  always_comb begin
    in_ready = (state == NORM);
  end

  // ---- write-back register stage ----
  // A double is counted at its HI edge only, so a flush in HI drops it from
  // retire_cnt as well as suppressing the high-word write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      retire_cnt <= '0;
      hiData     <= '0;
      hiAddr     <= '0;
    end else if (flush) begin
      rf_we <= 1'b0;
    end else if (state == HI) begin
      rf_we      <= 1'b1;
      rf_waddr   <= hiAddr;
      rf_wdata   <= hiData;
      retire_cnt <= retire_cnt + 1'b1;
    end else if (accept) begin
      rf_we    <= wb_en;
      rf_waddr <= dst;
      rf_wdata <= selData;
      if (effDbl) begin
        hiData <= mem_data_hi;
        hiAddr <= dst + 1'b1;
      end else begin
        retire_cnt <= retire_cnt + 1'b1;
      end
    end else begin
      rf_we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic              wb_en;
  logic [1:0]        src_sel;
  logic              dbl;
  logic [ADDR_W-1:0] dst;
  logic [DATA_W-1:0] alu_data, mem_data, port_data, imm_data, mem_data_hi;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [CNT_W-1:0]  retire_cnt;

  int nChecks = 0;
  int nFails  = 0;

  // expected writes, {addr, data}
  logic [ADDR_W+DATA_W-1:0] expQ[$];

  writeback_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .wb_en(wb_en), .src_sel(src_sel), .dbl(dbl), .dst(dst),
    .alu_data(alu_data), .mem_data(mem_data), .port_data(port_data),
    .imm_data(imm_data), .mem_data_hi(mem_data_hi),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic wb, input logic [1:0] sel,
                       input logic d, input logic [ADDR_W-1:0] ds,
                       input logic [DATA_W-1:0] val, input logic [DATA_W-1:0] hi);
    in_valid    = v;
    wb_en       = wb;
    src_sel     = sel;
    dbl         = d;
    dst         = ds;
    alu_data    = (sel == 2'd0) ? val : 16'hDEAD;
    mem_data    = (sel == 2'd1) ? val : 16'hDEAD;
    port_data   = (sel == 2'd2) ? val : 16'hDEAD;
    imm_data    = (sel == 2'd3) ? val : 16'hDEAD;
    mem_data_hi = hi;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    dbl      = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every write seen on the port must be the next expected one
  always @(negedge clk) begin
    if (!rst && rf_we) begin
      if (expQ.size() == 0) begin
        check("unexpected_write", 32'(rf_we), 32'd0);
      end else begin
        logic [ADDR_W+DATA_W-1:0] e;
        e = expQ.pop_front();
        check("wr_addr", 32'(rf_waddr), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
        check("wr_data", 32'(rf_wdata), 32'(e[DATA_W-1:0]));
      end
    end
  end

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 1'b0, '0, '0, '0);
    #1;
    check("rst_we", 32'(rf_we), 32'd0);
    check("rst_waddr", 32'(rf_waddr), 32'd0);
    check("rst_wdata", 32'(rf_wdata), 32'd0);
    check("rst_cnt", 32'(retire_cnt), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    step(); step();
    rst = 1'b0;
    step();

    // three singles back to back
    drive(1'b1, 1'b1, 2'd0, 1'b0, 3'd2, 16'h1234, '0); expQ.push_back({3'd2, 16'h1234});
    check("ready_s1", 32'(in_ready), 32'd1);
    step();
    drive(1'b1, 1'b1, 2'd3, 1'b0, 3'd5, 16'h00FF, '0); expQ.push_back({3'd5, 16'h00FF});
    check("ready_s2", 32'(in_ready), 32'd1);
    step();
    drive(1'b1, 1'b1, 2'd2, 1'b0, 3'd7, 16'hA5A5, '0); expQ.push_back({3'd7, 16'hA5A5});
    check("ready_s3", 32'(in_ready), 32'd1);
    step();
    idle();
    check("cnt_3", 32'(retire_cnt), 32'd3);
    step();
    check("idle_we", 32'(rf_we), 32'd0);

    // wb_en=0 still retires
    drive(1'b1, 1'b0, 2'd0, 1'b0, 3'd1, 16'hBEEF, '0);
    step();
    idle();
    check("nowb_we", 32'(rf_we), 32'd0);
    check("cnt_4", 32'(retire_cnt), 32'd4);
    step();

    // double with wrap of dst+1, next instruction held off during HI
    drive(1'b1, 1'b1, 2'd1, 1'b1, 3'd7, 16'h1111, 16'h2222);
    expQ.push_back({3'd7, 16'h1111});
    expQ.push_back({3'd0, 16'h2222});
    step();
    check("dbl_ready_hi", 32'(in_ready), 32'd0);
    check("dbl_cnt_lo", 32'(retire_cnt), 32'd4);
    drive(1'b1, 1'b1, 2'd0, 1'b0, 3'd3, 16'h4444, '0);
    expQ.push_back({3'd3, 16'h4444});
    step();
    check("dbl_ready_back", 32'(in_ready), 32'd1);
    check("dbl_cnt_hi", 32'(retire_cnt), 32'd5);
    step();
    idle();
    check("cnt_after_held", 32'(retire_cnt), 32'd6);

    // dbl ignored for ALU source
    drive(1'b1, 1'b1, 2'd0, 1'b1, 3'd4, 16'h3333, 16'h7777);
    expQ.push_back({3'd4, 16'h3333});
    step();
    idle();
    check("alu_dbl_ready", 32'(in_ready), 32'd1);
    check("alu_dbl_cnt", 32'(retire_cnt), 32'd7);
    step();
    check("alu_dbl_nohi", 32'(rf_we), 32'd0);

    // flush during HI cancels the high word
    drive(1'b1, 1'b1, 2'd1, 1'b1, 3'd1, 16'h5555, 16'h6666);
    expQ.push_back({3'd1, 16'h5555});
    step();
    idle();
    check("fl_ready_hi", 32'(in_ready), 32'd0);
    flush = 1'b1;
    step();
    check("fl_we", 32'(rf_we), 32'd0);
    check("fl_ready", 32'(in_ready), 32'd1);
    check("fl_cnt", 32'(retire_cnt), 32'd7);
    // flush with in_valid: nothing accepted
    drive(1'b1, 1'b1, 2'd0, 1'b0, 3'd6, 16'h7777, '0);
    step();
    flush = 1'b0;
    idle();
    check("flv_we", 32'(rf_we), 32'd0);
    check("flv_cnt", 32'(retire_cnt), 32'd7);
    step();

    // async reset in the middle of a double
    drive(1'b1, 1'b1, 2'd1, 1'b1, 3'd2, 16'h8888, 16'h9999);
    step();
    idle();
    check("rd_lo_addr", 32'(rf_waddr), 32'd2);
    check("rd_lo_data", 32'(rf_wdata), 32'h8888);
    #1 rst = 1'b1;
    #1;
    check("rd_we", 32'(rf_we), 32'd0);
    check("rd_waddr", 32'(rf_waddr), 32'd0);
    check("rd_wdata", 32'(rf_wdata), 32'd0);
    check("rd_cnt", 32'(retire_cnt), 32'd0);
    check("rd_ready", 32'(in_ready), 32'd1);
    step();
    rst = 1'b0;
    step();
    check("rd_post_we", 32'(rf_we), 32'd0);
    check("rd_post_ready", 32'(in_ready), 32'd1);
    step();

    // counter wrap at CNT_W=4
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 1'b0, 2'd3, 1'b0, 3'(i), 16'(i), '0);
      step();
    end
    idle();
    check("wrap_max", 32'(retire_cnt), 32'd15);
    drive(1'b1, 1'b0, 2'd3, 1'b0, 3'd0, 16'h0, '0);
    step();
    idle();
    check("wrap_zero", 32'(retire_cnt), 32'd0);
    step(); step();

    check("queue_drained", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule
